// File: rtl/swarm_if.sv
// swarm_if: invader swarm bus; game-state/frame/hit inputs and formation outputs.
//   master : drives game_state, frame_tick, hit_valid, hit_row, hit_col
//   slave  : drives hit_ack, alive_mask, alive_count, swarm_x, swarm_y, game_win, game_over
interface swarm_if #(
  parameter int ROWS = 5,
  parameter int COLS = 8
);
  logic [1:0]           game_state;
  logic                 frame_tick;
  logic                 hit_valid;
  logic [2:0]           hit_row;
  logic [2:0]           hit_col;
  logic                 hit_ack;
  logic [ROWS*COLS-1:0] alive_mask;
  logic [5:0]           alive_count;
  logic [9:0]           swarm_x;
  logic [9:0]           swarm_y;
  logic                 game_win;
  logic                 game_over;
  modport master (
    output game_state, frame_tick, hit_valid, hit_row, hit_col,
    input  hit_ack, alive_mask, alive_count, swarm_x, swarm_y, game_win, game_over
  );
  modport slave (
    input  game_state, frame_tick, hit_valid, hit_row, hit_col,
    output hit_ack, alive_mask, alive_count, swarm_x, swarm_y, game_win, game_over
  );
endinterface

// File: rtl/invader_swarm.sv
// invader_swarm: invader formation controller (alive bitmap, march/drop, hits, win/over).
//   clk, reset (async, active-high), bus (swarm_if.slave): game_state/frame_tick/hit_* in,
//   hit_ack/alive_mask/alive_count/swarm_x/swarm_y/game_win/game_over out, all registered.
//   Define SWARM_SPEEDUP_EN to make the move period shrink with the alive count.
module invader_swarm #(
  parameter int ROWS        = 5,
  parameter int COLS        = 8,
  parameter int CELL_W      = 16,
  parameter int CELL_H      = 16,
  parameter int X_START     = 64,
  parameter int Y_START     = 48,
  parameter int X_MAX       = 640,
  parameter int STEP_X      = 4,
  parameter int STEP_Y      = 8,
  parameter int Y_LOSE      = 416,
  parameter int BASE_PERIOD = 30,
  parameter int MIN_PERIOD  = 2,
  parameter int SPEED_SHIFT = 1
) (
  input logic   clk,
  input logic   reset,
  swarm_if.slave bus
);
  localparam int N = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam int FAST_MAX = MIN_PERIOD + (N >> SPEED_SHIFT);
  localparam int PMAX = BASE_PERIOD > FAST_MAX ? BASE_PERIOD : FAST_MAX;
  localparam int CW = $clog2(PMAX + 1);
  localparam logic [1:0] GS_START = 2'd0, GS_MAIN = 2'd1, GS_WIN = 2'd2, GS_LOSE = 2'd3;
  typedef enum logic [1:0] {IDLE, MARCH, WON, LOST} state_t;
  state_t        state;
  logic          dir_left;
  logic [CW-1:0] move_cnt, period;
  logic [CW:0]   cnt_next;
  logic [IW-1:0] hit_idx;
  logic          hit_ok, step, at_edge, over, leave;
`ifdef SWARM_SPEEDUP_EN
  assign period = CW'(MIN_PERIOD) + CW'(bus.alive_count >> SPEED_SHIFT);
`else
  assign period = CW'(BASE_PERIOD);
`endif
  assign cnt_next = {1'b0, move_cnt} + (CW+1)'(1);
  // >= rather than == so a period that shrinks below the running count still fires
  assign step = bus.frame_tick && cnt_next >= {1'b0, period};
  assign hit_idx = IW'(int'(bus.hit_row) * COLS + int'(bus.hit_col));
  assign hit_ok = bus.hit_valid && int'(bus.hit_row) < ROWS && int'(bus.hit_col) < COLS &&
                  bus.alive_mask[hit_idx];
  assign at_edge = dir_left ? bus.swarm_x < 10'(STEP_X)
                            : {1'b0, bus.swarm_x} + 11'(COLS * CELL_W + STEP_X) > 11'(X_MAX);
  assign over = {1'b0, bus.swarm_y} + 11'(ROWS * CELL_H) >= 11'(Y_LOSE);
  // WON/LOST stay put while the game FSM sits in MAIN or in its matching end state
  assign leave = bus.game_state != GS_MAIN &&
                 !(state == WON && bus.game_state == GS_WIN) &&
                 !(state == LOST && bus.game_state == GS_LOSE);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state           <= IDLE;
      dir_left        <= 1'b0;
      move_cnt        <= '0;
      bus.alive_mask  <= '1;
      bus.alive_count <= 6'(N);
      bus.swarm_x     <= 10'(X_START);
      bus.swarm_y     <= 10'(Y_START);
      bus.hit_ack     <= 1'b0;
      bus.game_win    <= 1'b0;
      bus.game_over   <= 1'b0;
    end else begin
      bus.hit_ack <= 1'b0;
      if (leave) begin
        state         <= IDLE;
        bus.game_win  <= 1'b0;
        bus.game_over <= 1'b0;
        if (state == IDLE && bus.game_state == GS_START) begin
          dir_left        <= 1'b0;
          move_cnt        <= '0;
          bus.alive_mask  <= '1;
          bus.alive_count <= 6'(N);
          bus.swarm_x     <= 10'(X_START);
          bus.swarm_y     <= 10'(Y_START);
        end
      end else if (state == IDLE) begin
        state <= MARCH;
      end else if (state == MARCH) begin
        if (bus.alive_count == '0) begin
          state        <= WON;
          bus.game_win <= 1'b1;
        end else if (over) begin
          state         <= LOST;
          bus.game_over <= 1'b1;
        end else begin
          if (hit_ok) begin
            bus.alive_mask[hit_idx] <= 1'b0;
            bus.alive_count         <= bus.alive_count - 6'd1;
            bus.hit_ack             <= 1'b1;
          end
          if (bus.frame_tick) move_cnt <= step ? '0 : cnt_next[CW-1:0];
          if (step && at_edge) begin
            bus.swarm_y <= bus.swarm_y + 10'(STEP_Y);
            dir_left    <= ~dir_left;
          end else if (step) begin
            bus.swarm_x <= dir_left ? bus.swarm_x - 10'(STEP_X) : bus.swarm_x + 10'(STEP_X);
          end
        end
      end
    end
endmodule
